// File: rtl/mdu_pkg.sv
// Shared types and constants for the multi-cycle multiply/divide unit.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FIXUP = 2'd2,
    ST_DONE  = 2'd3
  } mdu_state_t;

endpackage

// File: rtl/mdu_iter_step.sv
// One iteration of the sequencer: shift-add multiply step or restoring-divide step.
module mdu_iter_step
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   shreg,
  input  logic [WIDTH-1:0]   fixed_op,
  output logic [2*WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0]   shreg_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;
  logic           ge;
  logic           unused_diff_msb;

  always_comb begin
    sum             = '0;
    rem_sh          = '0;
    diff            = '0;
    ge              = 1'b0;
    acc_next        = acc;
    shreg_next      = shreg;
    unused_diff_msb = 1'b0;
    if (!is_div) begin
      // shreg holds the multiplier; its LSB gates the add into the upper half
      sum        = {1'b0, acc[2*WIDTH-1:WIDTH]} + (shreg[0] ? {1'b0, fixed_op} : '0);
      acc_next   = {sum, acc[WIDTH-1:1]};
      shreg_next = shreg >> 1;
    end else begin
      // shreg holds the dividend; its MSB feeds the remainder from the right
      rem_sh          = {acc[2*WIDTH-1:WIDTH], shreg[WIDTH-1]};
      ge              = rem_sh >= {1'b0, fixed_op};
      diff            = rem_sh - {1'b0, fixed_op};
      unused_diff_msb = diff[WIDTH];
      acc_next        = {(ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]),
                         acc[WIDTH-2:0], ge};
      shreg_next      = shreg << 1;
    end
  end

endmodule

// File: rtl/mdu_sequencer.sv
// MULT/MULTU/DIV/DIVU sequencer: one bit per cycle, sign fixup, HI/LO result registers.
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  mdu_state_t state_reg, state_next;

  logic               is_div_reg;
  logic               dbz_reg;
  logic               sign_a_reg;
  logic               sign_b_reg;
  logic [WIDTH-1:0]   shreg_reg;
  logic [WIDTH-1:0]   fixed_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [WIDTH-1:0]   hi_reg;
  logic [WIDTH-1:0]   lo_reg;

  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   shreg_next;
  logic               start_ok;
  logic               in_signed;
  logic               in_div;
  logic [WIDTH-1:0]   rs_mag;
  logic [WIDTH-1:0]   rt_mag;
  logic               signs_differ;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   hi_fix;
  logic [WIDTH-1:0]   lo_fix;

  assign start_ok  = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
  assign in_signed = ~op[0];
  assign in_div    = op[1];
  assign rs_mag    = (in_signed && rs_val[WIDTH-1]) ? -rs_val : rs_val;
  assign rt_mag    = (in_signed && rt_val[WIDTH-1]) ? -rt_val : rt_val;

  mdu_iter_step #(.WIDTH(WIDTH)) u_step (
    .is_div     (is_div_reg),
    .acc        (acc_reg),
    .shreg      (shreg_reg),
    .fixed_op   (fixed_reg),
    .acc_next   (acc_next),
    .shreg_next (shreg_next)
  );

  always_ff @(posedge clk) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (start) state_next = ST_RUN;
      ST_RUN:   if (cnt_reg == '0) state_next = ST_FIXUP;
      ST_FIXUP: state_next = ST_DONE;
      ST_DONE:  state_next = start ? ST_RUN : ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Divide by zero falls out naturally as remainder = dividend (sign restored
  // below); only the quotient needs forcing to all-ones.
  always_comb begin
    signs_differ = sign_a_reg ^ sign_b_reg;
    prod_fix     = signs_differ ? -acc_reg : acc_reg;
    quo_fix      = signs_differ ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
    rem_fix      = sign_a_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];
    hi_fix       = prod_fix[2*WIDTH-1:WIDTH];
    lo_fix       = prod_fix[WIDTH-1:0];
    if (is_div_reg) begin
      hi_fix = rem_fix;
      lo_fix = dbz_reg ? '1 : quo_fix;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      is_div_reg <= 1'b0;
      dbz_reg    <= 1'b0;
      sign_a_reg <= 1'b0;
      sign_b_reg <= 1'b0;
      shreg_reg  <= '0;
      fixed_reg  <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
    end else if (start_ok) begin
      is_div_reg <= in_div;
      dbz_reg    <= in_div && (rt_val == '0);
      sign_a_reg <= in_signed & rs_val[WIDTH-1];
      sign_b_reg <= in_signed & rt_val[WIDTH-1];
      shreg_reg  <= in_div ? rs_mag : rt_mag;
      fixed_reg  <= in_div ? rt_mag : rs_mag;
      acc_reg    <= '0;
      cnt_reg    <= CNT_W'(WIDTH - 1);
    end else if (state_reg == ST_RUN) begin
      acc_reg    <= acc_next;
      shreg_reg  <= shreg_next;
      cnt_reg    <= cnt_reg - 1'b1;
    end else if (state_reg == ST_FIXUP) begin
      hi_reg     <= hi_fix;
      lo_reg     <= lo_fix;
    end
  end

  assign busy        = (state_reg == ST_RUN) || (state_reg == ST_FIXUP);
  assign done        = (state_reg == ST_DONE);
  assign div_by_zero = (state_reg == ST_DONE) && dbz_reg;
  assign hi          = hi_reg;
  assign lo          = lo_reg;

endmodule
